// File: rtl/cortex_m0_pkg.sv
// Shared constants, sequencer state encoding and bit-scan helper for the
// cortex_m0 register file and its register-list sequencer.
package cortex_m0_pkg;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_BEAT = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // Scanning from the top down leaves the lowest set index as the result.
  function automatic logic [3:0] lowestSetBit(input logic [15:0] mask);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cortex_m0_reglist_seq.sv
// Register-list sequencer: walks a register bitmask in ascending order and
// presents one register index per valid/ready beat.
module cortex_m0_reglist_seq
  import cortex_m0_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [NREGS-1:0] i_list,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [3:0]       o_reg,
  output logic             o_busy,
  output logic             o_done
);

  seq_state_e       r_state;
  seq_state_e       w_stateNext;
  logic [NREGS-1:0] r_mask;
  logic [NREGS-1:0] w_maskNext;
  logic [NREGS-1:0] w_maskCleared;
  logic [3:0]       r_reg;
  logic [3:0]       w_regNext;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_reg   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_mask  <= w_maskNext;
      r_reg   <= w_regNext;
    end
  end

  assign w_maskCleared = r_mask & ~(NREGS'(1) << r_reg);

  // The next index is picked in the same cycle as the handshake, so
  // consecutive beats follow without a bubble.
  always_comb begin
    w_stateNext = r_state;
    w_maskNext  = r_mask;
    w_regNext   = r_reg;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_maskNext  = i_list;
          w_stateNext = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (|r_mask) begin
          w_regNext   = lowestSetBit(16'(r_mask));
          w_stateNext = ST_BEAT;
        end else begin
          w_stateNext = ST_DONE;
        end
      end
      ST_BEAT: begin
        if (i_ready) begin
          w_maskNext = w_maskCleared;
          if (|w_maskCleared) begin
            w_regNext   = lowestSetBit(16'(w_maskCleared));
            w_stateNext = ST_BEAT;
          end else begin
            w_stateNext = ST_DONE;
          end
        end
      end
      ST_DONE: w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  assign o_valid = (r_state == ST_BEAT);
  assign o_busy  = (r_state != ST_IDLE);
  assign o_done  = (r_state == ST_DONE);
  assign o_reg   = o_valid ? r_reg : 4'd0;

endmodule

// File: rtl/cortex_m0_regfile.sv
// Cortex-M0 register file with banked SP, PC advance path and list sequencer.
// Define CM0_RF_BYPASS_EN to forward same-edge write data to the read ports.
module cortex_m0_regfile
  import cortex_m0_pkg::*;
#(
  parameter int            BW       = 32,
  parameter int            NREGS    = 16,
  parameter int            NRD      = 2,
  parameter logic [BW-1:0] SP_RESET = '0,
  parameter logic [BW-1:0] PC_RESET = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NRD*4-1:0]  i_rd_addr,
  output logic [NRD*BW-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [3:0]        i_wr_addr,
  input  logic [BW-1:0]     i_wr_data,
  input  logic              i_spsel,
  input  logic              i_handler_mode,
  input  logic              i_pc_adv_en,
  input  logic [2:0]        i_pc_adv_inc,
  output logic [BW-1:0]     o_pc_out,
  output logic [BW-1:0]     o_msp_out,
  output logic [BW-1:0]     o_psp_out,
  input  logic              i_lst_start,
  input  logic [NREGS-1:0]  i_lst_list,
  output logic              o_lst_valid,
  input  logic              i_lst_ready,
  output logic [3:0]        o_lst_reg,
  output logic [BW-1:0]     o_lst_data,
  output logic              o_lst_busy,
  output logic              o_lst_done
);

  logic [BW-1:0] r_gpr [NREGS];
  logic [BW-1:0] r_msp;
  logic [BW-1:0] r_psp;
  logic [BW-1:0] r_pc;
  logic [BW-1:0] w_regView [NREGS];
  logic [BW-1:0] w_wrData;
  logic          w_useMsp;
  logic [3:0]    w_lstReg;

  function automatic logic [BW-1:0] alignWrite(input logic [3:0] addr, input logic [BW-1:0] data);
    logic [BW-1:0] v;
    v = data;
    if (addr == REG_SP)      v[1:0] = 2'b00;
    else if (addr == REG_PC) v[0]   = 1'b0;
    return v;
  endfunction

  assign w_useMsp = i_handler_mode | ~i_spsel;
  assign w_wrData = alignWrite(i_wr_addr, i_wr_data);

  // Architectural view: SP slot resolves to the active bank, PC slot to r_pc.
  always_comb begin
    for (int i = 0; i < NREGS; i++) w_regView[i] = r_gpr[i];
    w_regView[REG_SP] = w_useMsp ? r_msp : r_psp;
    w_regView[REG_PC] = r_pc;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) r_gpr[i] <= '0;
      r_msp <= SP_RESET;
      r_psp <= SP_RESET;
      r_pc  <= PC_RESET;
    end else begin
      if (i_wr_en) begin
        if (i_wr_addr == REG_SP) begin
          if (w_useMsp) r_msp <= w_wrData;
          else          r_psp <= w_wrData;
        end else if (i_wr_addr != REG_PC) begin
          r_gpr[i_wr_addr] <= w_wrData;
        end
      end
      if (i_wr_en && (i_wr_addr == REG_PC)) r_pc <= w_wrData;
      else if (i_pc_adv_en)                 r_pc <= r_pc + BW'(i_pc_adv_inc);
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [3:0]    w_addr;
    logic [BW-1:0] w_val;
    logic [BW-1:0] r_rdData;

    assign w_addr = i_rd_addr[4*k +: 4];
`ifdef CM0_RF_BYPASS_EN
    assign w_val = (i_wr_en && (i_wr_addr == w_addr)) ? w_wrData : w_regView[w_addr];
`else
    assign w_val = w_regView[w_addr];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_rdData <= '0;
      else          r_rdData <= w_val;
    end

    assign o_rd_data[BW*k +: BW] = r_rdData;
  end

  cortex_m0_reglist_seq #(.NREGS(NREGS)) u_seq (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_lst_start),
    .i_list  (i_lst_list),
    .i_ready (i_lst_ready),
    .o_valid (o_lst_valid),
    .o_reg   (w_lstReg),
    .o_busy  (o_lst_busy),
    .o_done  (o_lst_done)
  );

  assign o_lst_reg  = w_lstReg;
  assign o_lst_data = o_lst_valid ? w_regView[w_lstReg] : '0;
  assign o_pc_out   = r_pc;
  assign o_msp_out  = r_msp;
  assign o_psp_out  = r_psp;

endmodule

// File: tb/tb_cortex_m0_regfile.sv
// Self-checking bench for cortex_m0_regfile: a behavioural model compared every
// cycle, plus directed checks with hand-computed literals.
module tb_cortex_m0_regfile;

`ifdef CM0_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  rdAddr;
  logic [63:0] rdData;
  logic        wrEn;
  logic [3:0]  wrAddr;
  logic [31:0] wrData;
  logic        spsel;
  logic        handlerMode;
  logic        pcAdvEn;
  logic [2:0]  pcAdvInc;
  logic [31:0] pcOut, mspOut, pspOut;
  logic        lstStart;
  logic [15:0] lstList;
  logic        lstValid;
  logic        lstReady;
  logic [3:0]  lstReg;
  logic [31:0] lstData;
  logic        lstBusy;
  logic        lstDone;

  int total = 0;
  int bad = 0;
  int doneCount = 0;
  int beatLog[$];

  // Behavioural model state
  logic [31:0] mReg [16];
  logic [31:0] mMsp, mPsp, mPc;
  logic [31:0] mRd [2];
  int          mPhase;
  int          mQ[$];

  cortex_m0_regfile dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_rd_addr      (rdAddr),
    .o_rd_data      (rdData),
    .i_wr_en        (wrEn),
    .i_wr_addr      (wrAddr),
    .i_wr_data      (wrData),
    .i_spsel        (spsel),
    .i_handler_mode (handlerMode),
    .i_pc_adv_en    (pcAdvEn),
    .i_pc_adv_inc   (pcAdvInc),
    .o_pc_out       (pcOut),
    .o_msp_out      (mspOut),
    .o_psp_out      (pspOut),
    .i_lst_start    (lstStart),
    .i_lst_list     (lstList),
    .o_lst_valid    (lstValid),
    .i_lst_ready    (lstReady),
    .o_lst_reg      (lstReg),
    .o_lst_data     (lstData),
    .o_lst_busy     (lstBusy),
    .o_lst_done     (lstDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [3:0] a);
    if (a == 4'd13) return (handlerMode | ~spsel) ? mMsp : mPsp;
    if (a == 4'd15) return mPc;
    return mReg[a];
  endfunction

  function automatic logic [31:0] modelAlign(input logic [3:0] a, input logic [31:0] d);
    if (a == 4'd13) return d & 32'hFFFF_FFFC;
    if (a == 4'd15) return d & 32'hFFFF_FFFE;
    return d;
  endfunction

  task automatic modelStep();
    logic [3:0] a;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mReg[i] = 32'h0;
      mMsp = 32'h0; mPsp = 32'h0; mPc = 32'h0;
      mRd[0] = 32'h0; mRd[1] = 32'h0;
      mPhase = 0;
      mQ.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        a = rdAddr[4*k +: 4];
        mRd[k] = modelRead(a);
        if (BYP && wrEn && (wrAddr == a)) mRd[k] = modelAlign(wrAddr, wrData);
      end
      // Sequencer: idle -> one scan cycle -> one beat per accepted handshake -> one done cycle
      case (mPhase)
        0: if (lstStart) begin
             for (int i = 0; i < 16; i++) if (lstList[i]) mQ.push_back(i);
             mPhase = 1;
           end
        1: mPhase = (mQ.size() > 0) ? 2 : 3;
        2: if (lstReady) begin
             void'(mQ.pop_front());
             mPhase = (mQ.size() > 0) ? 2 : 3;
           end
        default: mPhase = 0;
      endcase
      if (wrEn) begin
        if (wrAddr == 4'd13) begin
          if (handlerMode | ~spsel) mMsp = modelAlign(wrAddr, wrData);
          else                      mPsp = modelAlign(wrAddr, wrData);
        end else if (wrAddr == 4'd15) begin
          mPc = modelAlign(wrAddr, wrData);
        end else begin
          mReg[wrAddr] = wrData;
        end
      end
      if (!(wrEn && wrAddr == 4'd15) && pcAdvEn) mPc = mPc + {29'b0, pcAdvInc};
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      modelStep();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (rst_n === 1'b1 && lstValid === 1'b1 && lstReady === 1'b1) beatLog.push_back(int'(lstReg));
    end
  end

  // Every-cycle comparison against the model
  initial begin
    logic        eValid;
    logic [31:0] eReg, eData;
    forever begin
      @(posedge clk);
      #2;
      eValid = (mPhase == 2);
      eReg   = eValid ? 32'(mQ[0]) : 32'h0;
      eData  = eValid ? modelRead(4'(mQ[0])) : 32'h0;
      checkOutput("rd0", rdData[31:0], mRd[0]);
      checkOutput("rd1", rdData[63:32], mRd[1]);
      checkOutput("pc", pcOut, mPc);
      checkOutput("msp", mspOut, mMsp);
      checkOutput("psp", pspOut, mPsp);
      checkOutput("lst_valid", {31'b0, lstValid}, {31'b0, eValid});
      checkOutput("lst_reg", {28'b0, lstReg}, eReg);
      checkOutput("lst_data", lstData, eData);
      checkOutput("lst_busy", {31'b0, lstBusy}, {31'b0, mPhase != 0});
      checkOutput("lst_done", {31'b0, lstDone}, {31'b0, mPhase == 3});
      if (lstDone === 1'b1) doneCount++;
    end
  end

  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic [3:0] ra0, input logic [3:0] ra1,
                               input logic adv, input logic [2:0] inc);
    wrEn = we; wrAddr = wa; wrData = wd;
    rdAddr = {ra1, ra0};
    pcAdvEn = adv; pcAdvInc = inc;
    @(negedge clk);
  endtask

  task automatic waitValid();
    for (int i = 0; i < 20 && lstValid !== 1'b1; i++) @(negedge clk);
    checkOutput("wait_valid", {31'b0, lstValid}, 32'h1);
  endtask

  task automatic waitIdle();
    lstReady = 1'b1;
    for (int i = 0; i < 40 && lstBusy !== 1'b0; i++) @(negedge clk);
    checkOutput("wait_idle", {31'b0, lstBusy}, 32'h0);
    lstReady = 1'b0;
  endtask

  initial begin
    int          dc0;
    int          nb0;
    logic [3:0]  holdReg;
    logic [31:0] holdData;
    logic        pat [7];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    rdAddr = '0; wrEn = 0; wrAddr = '0; wrData = '0;
    spsel = 0; handlerMode = 0; pcAdvEn = 0; pcAdvInc = '0;
    lstStart = 0; lstList = '0; lstReady = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] reset values");
    for (int a = 0; a < 16; a += 2) begin
      applyStimulus(0, 4'd0, 32'h0, 4'(a), 4'(a + 1), 0, 3'd0);
      checkOutput("rst_rd0", rdData[31:0], 32'h0);
      checkOutput("rst_rd1", rdData[63:32], 32'h0);
    end
    checkOutput("rst_pc", pcOut, 32'h0);
    checkOutput("rst_sp", mspOut, 32'h0);

    $display("[TB] write and read-during-write");
    applyStimulus(1, 4'd3, 32'hDEAD_BEEF, 4'd3, 4'd0, 0, 3'd0);
    checkOutput("rdw_same", rdData[31:0], BYP ? 32'hDEAD_BEEF : 32'h0);
    applyStimulus(0, 4'd0, 32'h0, 4'd0, 4'd3, 0, 3'd0);
    checkOutput("rd_next", rdData[63:32], 32'hDEAD_BEEF);

    $display("[TB] SP banking");
    applyStimulus(1, 4'd13, 32'h2000_0007, 4'd13, 4'd0, 0, 3'd0);
    checkOutput("rdw_sp", rdData[31:0], BYP ? 32'h2000_0004 : 32'h0);
    checkOutput("msp_align", mspOut, 32'h2000_0004);
    spsel = 1'b1;
    applyStimulus(1, 4'd13, 32'h1000_0000, 4'd0, 4'd0, 0, 3'd0);
    checkOutput("psp_set", pspOut, 32'h1000_0000);
    checkOutput("msp_kept", mspOut, 32'h2000_0004);
    applyStimulus(0, 4'd0, 32'h0, 4'd13, 4'd0, 0, 3'd0);
    checkOutput("sp_psp", rdData[31:0], 32'h1000_0000);
    handlerMode = 1'b1;
    applyStimulus(0, 4'd0, 32'h0, 4'd13, 4'd0, 0, 3'd0);
    checkOutput("sp_handler", rdData[31:0], 32'h2000_0004);

    $display("[TB] PC path");
    applyStimulus(1, 4'd15, 32'hFFFF_FFFE, 4'd15, 4'd0, 0, 3'd0);
    checkOutput("pc_wr", pcOut, 32'hFFFF_FFFE);
    applyStimulus(0, 4'd0, 32'h0, 4'd15, 4'd0, 1, 3'd4);
    checkOutput("pc_wrap", pcOut, 32'h0000_0002);
    applyStimulus(1, 4'd15, 32'h0000_0101, 4'd15, 4'd0, 1, 3'd2);
    checkOutput("pc_prio", pcOut, 32'h0000_0100);
    applyStimulus(0, 4'd0, 32'h0, 4'd15, 4'd0, 1, 3'd2);
    checkOutput("pc_adv2", pcOut, 32'h0000_0102);

    $display("[TB] list 40F1 with back-pressure");
    handlerMode = 1'b0; spsel = 1'b0;
    applyStimulus(1, 4'd0, 32'hA000_0000, 4'd0, 4'd0, 0, 3'd0);
    applyStimulus(1, 4'd4, 32'hA000_0004, 4'd0, 4'd0, 0, 3'd0);
    applyStimulus(1, 4'd5, 32'hA000_0005, 4'd0, 4'd0, 0, 3'd0);
    applyStimulus(1, 4'd6, 32'hA000_0006, 4'd0, 4'd0, 0, 3'd0);
    applyStimulus(1, 4'd7, 32'hA000_0007, 4'd0, 4'd0, 0, 3'd0);
    applyStimulus(1, 4'd14, 32'hA000_000E, 4'd0, 4'd0, 0, 3'd0);
    wrEn = 0;
    dc0 = doneCount;
    beatLog.delete();
    lstList = 16'h40F1; lstStart = 1'b1;
    @(negedge clk);
    lstStart = 1'b0;
    waitValid();
    checkOutput("first_reg", {28'b0, lstReg}, 32'd0);
    checkOutput("first_data", lstData, 32'hA000_0000);
    for (int i = 0; i < 7; i++) begin
      lstReady = pat[i];
      wrEn = (i == 4); wrAddr = 4'd7; wrData = 32'h7777_0000;
      holdReg = lstReg; holdData = lstData;
      @(negedge clk);
      if (i == 1) begin
        checkOutput("hold_reg", {28'b0, lstReg}, {28'b0, holdReg});
        checkOutput("hold_data", lstData, holdData);
        checkOutput("hold_r4", lstData, 32'hA000_0004);
      end
      if (i == 4) checkOutput("live_r7", lstData, 32'h7777_0000);
    end
    wrEn = 0; lstReady = 0;
    waitIdle();
    checkOutput("beats_n", beatLog.size(), 32'd6);
    if (beatLog.size() == 6) begin
      checkOutput("beat0", beatLog[0], 32'd0);
      checkOutput("beat1", beatLog[1], 32'd4);
      checkOutput("beat2", beatLog[2], 32'd5);
      checkOutput("beat3", beatLog[3], 32'd6);
      checkOutput("beat4", beatLog[4], 32'd7);
      checkOutput("beat5", beatLog[5], 32'd14);
    end
    checkOutput("done_once", doneCount - dc0, 32'd1);

    $display("[TB] empty list and ignored start");
    nb0 = beatLog.size();
    lstList = 16'h0000; lstStart = 1'b1;
    @(negedge clk);
    checkOutput("empty_busy", {31'b0, lstBusy}, 32'h1);
    checkOutput("empty_valid", {31'b0, lstValid}, 32'h0);
    lstList = 16'hFFFF;
    @(negedge clk);
    checkOutput("empty_done", {31'b0, lstDone}, 32'h1);
    lstStart = 1'b0;
    @(negedge clk);
    checkOutput("empty_idle", {31'b0, lstBusy | lstDone}, 32'h0);
    checkOutput("empty_nobeat", beatLog.size() - nb0, 32'd0);

    lstList = 16'h0006; lstStart = 1'b1;
    @(negedge clk);
    lstList = 16'hFFFF;
    @(negedge clk);
    lstStart = 1'b0;
    waitIdle();
    checkOutput("ign_n", beatLog.size() - nb0, 32'd2);
    if (beatLog.size() - nb0 == 2) begin
      checkOutput("ign_b0", beatLog[nb0], 32'd1);
      checkOutput("ign_b1", beatLog[nb0 + 1], 32'd2);
    end

    $display("[TB] reset mid-beat");
    dc0 = doneCount;
    lstList = 16'h8001; lstStart = 1'b1;
    @(negedge clk);
    lstStart = 1'b0;
    waitValid();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", {31'b0, lstValid}, 32'h0);
    checkOutput("rst_done", {31'b0, lstDone}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 4'd0, 32'h0, 4'd3, 4'd15, 0, 3'd0);
    checkOutput("rst2_r3", rdData[31:0], 32'h0);
    checkOutput("rst2_pc", rdData[63:32], 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("rst_nodone", doneCount - dc0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
